core_output_buf: RTL and testbench

// Downstream stage of the sha512crypt core. Captures the 8 x 64-bit result

---
 rtl/core_output_buf.sv | 137 +++++++++++++
 tb/tb_core_output_buf.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/core_output_buf.sv
// core_output_buf: slot buffer capturing 8-word sha512crypt core records and replaying them word by word
module core_output_buf #(
   parameter int SLOTS    = 2,
   parameter int GAP_SYNC = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] core_dout,
   input  logic        core_dout_en,
   input  logic        core_dout_ctx_num,
   input  logic        core_dout_seq_num,
   output logic [63:0] dout,
   output logic        dout_ctx_num,
   output logic        dout_seq_num,
   output logic [2:0]  dout_word_idx,
   output logic        empty,
   input  logic        rd_en,
   output logic        overflow
);
   localparam int SW = $clog2(SLOTS);
   localparam int GW = $clog2(GAP_SYNC + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_SYNC - 1);
   typedef enum logic [1:0] {SYNC, IDLE, CAPTURE, DROP} state_t;
   state_t            state_q, state_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [SW-1:0]     wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
   logic [2:0]        wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, drop_cnt_q, drop_cnt_d;
   logic [SLOTS-1:0]  full_q, full_d, ctx_q, ctx_d, seq_q, seq_d;
   logic              overflow_q, overflow_d, wr_pend_q, wr_pend_d, wr_last_q, wr_last_d;
   logic [SW+2:0]     wr_addr_q, wr_addr_d;
   logic [63:0]       mem_q [SLOTS*8];
   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      wr_slot_d  = wr_slot_q;
      wr_cnt_d   = wr_cnt_q;
      drop_cnt_d = drop_cnt_q;
      rd_slot_d  = rd_slot_q;
      rd_cnt_d   = rd_cnt_q;
      full_d     = full_q;
      ctx_d      = ctx_q;
      seq_d      = seq_q;
      overflow_d = overflow_q;
      wr_pend_d  = 1'b0;
      wr_last_d  = 1'b0;
      wr_addr_d  = wr_addr_q;
      // A slot becomes readable on the edge that stores its last word
      if (wr_pend_q && wr_last_q) full_d[wr_addr_q[SW+2:3]] = 1'b1;
      if (rd_en && full_q[rd_slot_q]) begin
         rd_cnt_d = rd_cnt_q + 1'b1;
         if (rd_cnt_q == 3'd7) begin
            full_d[rd_slot_q] = 1'b0;
            rd_slot_d = rd_slot_q + 1'b1;
         end
      end
      case (state_q)
         SYNC: begin
            gap_d = core_dout_en ? '0 : gap_q + 1'b1;
            if (!core_dout_en && gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = IDLE;
            end
         end
         IDLE: if (core_dout_en) begin
            if (full_q[wr_slot_q]) begin
               state_d    = DROP;
               drop_cnt_d = 3'd1;
               overflow_d = 1'b1;
            end else begin
               state_d           = CAPTURE;
               wr_pend_d         = 1'b1;
               wr_addr_d         = {wr_slot_q, 3'd0};
               wr_cnt_d          = 3'd1;
               ctx_d[wr_slot_q]  = core_dout_ctx_num;
               seq_d[wr_slot_q]  = core_dout_seq_num;
            end
         end
         CAPTURE: if (core_dout_en) begin
            wr_pend_d = 1'b1;
            wr_addr_d = {wr_slot_q, wr_cnt_q};
            wr_cnt_d  = wr_cnt_q + 1'b1;
            if (wr_cnt_q == 3'd7) begin
               wr_last_d = 1'b1;
               wr_slot_d = wr_slot_q + 1'b1;
               state_d   = IDLE;
            end
         end
         DROP: if (core_dout_en) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
            if (drop_cnt_q == 3'd7) state_d = IDLE;
         end
         default: state_d = SYNC;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= SYNC;
         gap_q      <= '0;
         wr_slot_q  <= '0;
         wr_cnt_q   <= '0;
         drop_cnt_q <= '0;
         rd_slot_q  <= '0;
         rd_cnt_q   <= '0;
         full_q     <= '0;
         ctx_q      <= '0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
         wr_pend_q  <= 1'b0;
         wr_last_q  <= 1'b0;
         wr_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         wr_slot_q  <= wr_slot_d;
         wr_cnt_q   <= wr_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         rd_slot_q  <= rd_slot_d;
         rd_cnt_q   <= rd_cnt_d;
         full_q     <= full_d;
         ctx_q      <= ctx_d;
         seq_q      <= seq_d;
         overflow_q <= overflow_d;
         wr_pend_q  <= wr_pend_d;
         wr_last_q  <= wr_last_d;
         wr_addr_q  <= wr_addr_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_pend_q && !rst) mem_q[wr_addr_q] <= core_dout;
   end
   assign dout          = mem_q[{rd_slot_q, rd_cnt_q}];
   assign dout_ctx_num  = ctx_q[rd_slot_q];
   assign dout_seq_num  = seq_q[rd_slot_q];
   assign dout_word_idx = rd_cnt_q;
   assign empty         = ~full_q[rd_slot_q];
   assign overflow      = overflow_q;
endmodule

// File: tb/tb_core_output_buf.sv
// tb_core_output_buf: directed checks of capture, drop, FWFT readout and reset resync
module tb_core_output_buf;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] core_dout = '0;
   logic        core_dout_en = 1'b0;
   logic        core_dout_ctx_num = 1'b0;
   logic        core_dout_seq_num = 1'b0;
   logic [63:0] dout;
   logic        dout_ctx_num, dout_seq_num, empty, overflow;
   logic [2:0]  dout_word_idx;
   logic        rd_en = 1'b0;
   int          n_chk = 0, n_fail = 0, ridx = 0;
   logic        stream_chk = 1'b0;
   core_output_buf #(.SLOTS(2), .GAP_SYNC(4)) dut (
      .clk(clk), .rst(rst), .core_dout(core_dout), .core_dout_en(core_dout_en),
      .core_dout_ctx_num(core_dout_ctx_num), .core_dout_seq_num(core_dout_seq_num),
      .dout(dout), .dout_ctx_num(dout_ctx_num), .dout_seq_num(dout_seq_num),
      .dout_word_idx(dout_word_idx), .empty(empty), .rd_en(rd_en), .overflow(overflow)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // While streaming with rd_en held, every word consumed is checked against its arrival order
   task automatic tick();
      if (stream_chk && rd_en && !empty) begin
         chk("stream_data", dout, 64'h5000 + 64'((ridx / 8) * 256 + ridx % 8));
         chk("stream_idx", 64'(dout_word_idx), 64'(ridx % 8));
         chk("stream_ctx", 64'(dout_ctx_num), 64'((ridx / 8) % 2));
         chk("stream_seq", 64'(dout_seq_num), 64'((ridx / 16) % 2));
         ridx++;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic write_part(input logic [63:0] base, input logic ctx, input logic seq,
                             input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         core_dout_en = 1'b1;
         core_dout_ctx_num = ctx;
         core_dout_seq_num = seq;
         core_dout = '0;
         tick();
         core_dout_en = 1'b0;
         core_dout = base + 64'(i);
         tick();
      end
   endtask
   task automatic read_rec(input logic [63:0] base, input logic ctx, input logic seq, input int n);
      for (int i = 0; i < n; i++) begin
         chk("rd_empty", 64'(empty), 64'(0));
         chk("rd_data", dout, base + 64'(i));
         chk("rd_idx", 64'(dout_word_idx), 64'(i));
         chk("rd_ctx", 64'(dout_ctx_num), 64'(ctx));
         chk("rd_seq", 64'(dout_seq_num), 64'(seq));
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
      end
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask
   initial begin
      idle(2);
      rst = 1'b0;
      chk("rst_empty", 64'(empty), 64'(1));
      chk("rst_overflow", 64'(overflow), 64'(0));
      chk("rst_idx", 64'(dout_word_idx), 64'(0));
      chk("rst_ctx", 64'(dout_ctx_num), 64'(0));
      chk("rst_seq", 64'(dout_seq_num), 64'(0));
      idle(6);
      // 1: single record, availability the cycle after the last write
      write_part(64'h1000, 1'b1, 1'b0, 0, 7);
      core_dout_en = 1'b1;
      tick();
      core_dout_en = 1'b0;
      core_dout = 64'h1007;
      chk("t1_empty_during_last_write", 64'(empty), 64'(1));
      tick();
      chk("t1_empty_after_last_write", 64'(empty), 64'(0));
      read_rec(64'h1000, 1'b1, 1'b0, 8);
      chk("t1_empty_end", 64'(empty), 64'(1));
      // 2: three records into two slots, third dropped
      write_part(64'h2000, 1'b0, 1'b1, 0, 8);
      write_part(64'h3000, 1'b1, 1'b1, 0, 8);
      chk("t2_overflow_before", 64'(overflow), 64'(0));
      write_part(64'h4000, 1'b1, 1'b0, 0, 8);
      chk("t2_overflow_after", 64'(overflow), 64'(1));
      read_rec(64'h2000, 1'b0, 1'b1, 8);
      read_rec(64'h3000, 1'b1, 1'b1, 8);
      chk("t2_empty_end", 64'(empty), 64'(1));
      chk("t2_overflow_sticky", 64'(overflow), 64'(1));
      // 3: rd_en held while four records stream
      do_reset();
      chk("t3_overflow_cleared", 64'(overflow), 64'(0));
      idle(6);
      stream_chk = 1'b1;
      rd_en = 1'b1;
      for (int r = 0; r < 4; r++)
         write_part(64'h5000 + 64'(r * 256), 1'(r % 2), 1'((r / 2) % 2), 0, 8);
      idle(12);
      rd_en = 1'b0;
      stream_chk = 1'b0;
      chk("t3_words_read", 64'(ridx), 64'(32));
      chk("t3_overflow", 64'(overflow), 64'(0));
      chk("t3_empty_end", 64'(empty), 64'(1));
      // 4: reset mid-record, trailing pulses must not start a record
      write_part(64'h6100, 1'b0, 1'b0, 0, 4);
      do_reset();
      write_part(64'h6100, 1'b0, 1'b0, 4, 4);
      idle(6);
      chk("t4_empty_after_trailing", 64'(empty), 64'(1));
      chk("t4_overflow", 64'(overflow), 64'(0));
      write_part(64'h6000, 1'b1, 1'b1, 0, 8);
      read_rec(64'h6000, 1'b1, 1'b1, 8);
      chk("t4_empty_end", 64'(empty), 64'(1));
      // 5: rd_en while empty has no effect
      rd_en = 1'b1;
      idle(3);
      rd_en = 1'b0;
      chk("t5_idx", 64'(dout_word_idx), 64'(0));
      chk("t5_empty", 64'(empty), 64'(1));
      write_part(64'h7000, 1'b0, 1'b1, 0, 8);
      read_rec(64'h7000, 1'b0, 1'b1, 8);
      chk("t5_empty_end", 64'(empty), 64'(1));
      // 6: reset during readout at word 4
      write_part(64'h8000, 1'b1, 1'b0, 0, 8);
      read_rec(64'h8000, 1'b1, 1'b0, 4);
      chk("t6_idx_before_rst", 64'(dout_word_idx), 64'(4));
      rd_en = 1'b1;
      do_reset();
      rd_en = 1'b0;
      chk("t6_empty", 64'(empty), 64'(1));
      chk("t6_overflow", 64'(overflow), 64'(0));
      chk("t6_idx", 64'(dout_word_idx), 64'(0));
      idle(6);
      write_part(64'h9000, 1'b0, 1'b0, 0, 8);
      read_rec(64'h9000, 1'b0, 1'b0, 8);
      chk("t6_empty_end", 64'(empty), 64'(1));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
